// File: rtl/mult_shift_add.sv
// Sequential shift-and-add multiplier with a held done pulse.
// Define MULT_SIGNED_EN for two's complement operands.
module mult_shift_add #(
    parameter int WIDTH     = 16,
    parameter int DONE_HOLD = 31
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               init,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] pp,
    output logic               busy,
    output logic               done
);

    localparam int PW = 2 * WIDTH;
    localparam logic [7:0] HOLD_LAST = 8'(DONE_HOLD - 1);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        ADD,
        SHIFT,
        END
    } state_t;

    state_t           state;
    logic [PW-1:0]    mcand;
    logic [WIDTH-1:0] mplier;
    logic [PW-1:0]    acc;
    logic [7:0]       cnt;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [PW-1:0]    result;

`ifdef MULT_SIGNED_EN
    logic sign;

    // The most negative value negates to itself, which is its correct
    // unsigned magnitude.
    assign a_mag  = a[WIDTH-1] ? (~a + 1'b1) : a;
    assign b_mag  = b[WIDTH-1] ? (~b + 1'b1) : b;
    assign result = sign ? (~acc + 1'b1) : acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sign <= 1'b0;
        end else if (state == IDLE && init) begin
            sign <= a[WIDTH-1] ^ b[WIDTH-1];
        end
    end
`else
    assign a_mag  = a;
    assign b_mag  = b;
    assign result = acc;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            pp     <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (init) begin
                        mcand  <= {{WIDTH{1'b0}}, a_mag};
                        mplier <= b_mag;
                        acc    <= '0;
                        busy   <= 1'b1;
                        state  <= CHECK;
                    end
                end
                CHECK: begin
                    if (mplier == '0) begin
                        pp    <= result;
                        cnt   <= '0;
                        done  <= 1'b1;
                        state <= END;
                    end else if (mplier[0]) begin
                        state <= ADD;
                    end else begin
                        state <= SHIFT;
                    end
                end
                ADD: begin
                    acc   <= acc + mcand;
                    state <= SHIFT;
                end
                SHIFT: begin
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    state  <= CHECK;
                end
                END: begin
                    cnt <= cnt + 8'd1;
                    if (cnt == HOLD_LAST) begin
                        done  <= 1'b0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_shift_add.sv
// Directed-vector bench for mult_shift_add (8-bit/hold 4 and 16-bit/hold 1).
// Expected values follow MULT_SIGNED_EN when it is defined.
module tb_mult_shift_add;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        init8 = 1'b0;
    logic [7:0]  a8 = '0;
    logic [7:0]  b8 = '0;
    logic [15:0] pp8;
    logic        busy8;
    logic        done8;

    logic        init16 = 1'b0;
    logic [15:0] a16 = '0;
    logic [15:0] b16 = '0;
    logic [31:0] pp16;
    logic        busy16;
    logic        done16;

    int n_checks = 0;
    int n_fail = 0;

`ifdef MULT_SIGNED_EN
    localparam logic [15:0] EXP_FF  = 16'h0001;
    localparam int          N_FF    = 4;
    localparam int          N_0FF   = 4;
    localparam logic [31:0] EXP_W   = 32'h0000_0001;
    localparam int          N_W     = 4;
`else
    localparam logic [15:0] EXP_FF  = 16'hFE01;
    localparam int          N_FF    = 25;
    localparam int          N_0FF   = 25;
    localparam logic [31:0] EXP_W   = 32'hFFFE_0001;
    localparam int          N_W     = 49;
`endif

    always #5 clk = ~clk;

    mult_shift_add #(.WIDTH(8), .DONE_HOLD(4)) dut8 (
        .clk(clk), .rst(rst), .init(init8), .a(a8), .b(b8),
        .pp(pp8), .busy(busy8), .done(done8)
    );

    mult_shift_add #(.WIDTH(16), .DONE_HOLD(1)) dut16 (
        .clk(clk), .rst(rst), .init(init16), .a(a16), .b(b16),
        .pp(pp16), .busy(busy16), .done(done16)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench just after the edge that accepts init.
    task automatic start8(input logic [7:0] x, input logic [7:0] y);
        tick();
        init8 = 1'b1;
        a8 = x;
        b8 = y;
        tick();
        init8 = 1'b0;
    endtask

    // n = edges after the accepting edge until done is seen (latency - 1).
    task automatic wait_done8(output int n);
        n = 0;
        while (!done8 && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic hold8(output int h);
        h = 0;
        while (done8 && h < 300) begin
            tick();
            h++;
        end
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #2;
        n_checks++;
        if (busy8 !== 1'b0 || done8 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags8: busy=%b done=%b want 0 0", busy8, done8);
        end
        n_checks++;
        if (pp8 !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_pp8: got %h want 0000", pp8);
        end
        n_checks++;
        if (busy16 !== 1'b0 || done16 !== 1'b0 || pp16 !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_dut16: busy=%b done=%b pp=%h want 0 0 0",
                     busy16, done16, pp16);
        end
        tick();
        tick();
        #2 rst = 1'b0;
    endtask

    task automatic test_basic();
        int n, h;
        start8(8'd5, 8'd3);
        wait_done8(n);
        n_checks++;
        if (n !== 7) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d edges want 7", n);
        end
        n_checks++;
        if (pp8 !== 16'd15) begin
            n_fail++;
            $display("FAIL basic_pp: got %0d want 15", pp8);
        end
        hold8(h);
        n_checks++;
        if (h !== 4) begin
            n_fail++;
            $display("FAIL basic_hold: got %0d cycles want 4", h);
        end
        tick();
        n_checks++;
        if (busy8 !== 1'b0 || pp8 !== 16'd15) begin
            n_fail++;
            $display("FAIL basic_idle: busy=%b pp=%0d want 0 15", busy8, pp8);
        end
    endtask

    task automatic test_zero();
        int n, h;
        start8(8'd200, 8'd0);
        wait_done8(n);
        n_checks++;
        if (n !== 1) begin
            n_fail++;
            $display("FAIL zero_b_latency: got %0d edges want 1", n);
        end
        n_checks++;
        if (pp8 !== 16'd0) begin
            n_fail++;
            $display("FAIL zero_b_pp: got %h want 0000", pp8);
        end
        hold8(h);
        start8(8'd0, 8'd255);
        wait_done8(n);
        n_checks++;
        if (n !== N_0FF) begin
            n_fail++;
            $display("FAIL zero_a_latency: got %0d edges want %0d", n, N_0FF);
        end
        n_checks++;
        if (pp8 !== 16'd0) begin
            n_fail++;
            $display("FAIL zero_a_pp: got %h want 0000", pp8);
        end
        hold8(h);
    endtask

    task automatic test_back_to_back();
        int n, h, cnt;
        tick();
        init8 = 1'b1;
        a8 = 8'hFF;
        b8 = 8'hFF;
        tick();
        wait_done8(n);
        n_checks++;
        if (n !== N_FF) begin
            n_fail++;
            $display("FAIL max_latency: got %0d edges want %0d", n, N_FF);
        end
        n_checks++;
        if (pp8 !== EXP_FF) begin
            n_fail++;
            $display("FAIL max_pp: got %h want %h", pp8, EXP_FF);
        end
        hold8(h);
        n_checks++;
        if (h !== 4) begin
            n_fail++;
            $display("FAIL b2b_hold: got %0d cycles want 4", h);
        end
        n_checks++;
        if (busy8 !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_idle: busy=%b want 0", busy8);
        end
        a8 = 8'd2;
        b8 = 8'd3;
        tick();
        n_checks++;
        if (busy8 !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_accept: busy=%b want 1", busy8);
        end
        init8 = 1'b0;
        tick();
        n_checks++;
        if (pp8 !== EXP_FF) begin
            n_fail++;
            $display("FAIL b2b_pp_stable: got %h want %h", pp8, EXP_FF);
        end
        wait_done8(n);
        n_checks++;
        if (n !== 6 || pp8 !== 16'd6) begin
            n_fail++;
            $display("FAIL b2b_second: edges=%0d pp=%0d want 6 6", n + 1, pp8);
        end
        hold8(h);
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (busy8) cnt++;
        end
        n_checks++;
        if (cnt !== 0) begin
            n_fail++;
            $display("FAIL b2b_no_queue: busy cycles=%0d want 0", cnt);
        end
    endtask

    task automatic test_reset_abort();
        int n, h, cnt;
        start8(8'd7, 8'd9);
        tick();
        tick();
        #3 rst = 1'b1;
        #1;
        n_checks++;
        if (busy8 !== 1'b0 || done8 !== 1'b0 || pp8 !== 16'd0) begin
            n_fail++;
            $display("FAIL abort_async: busy=%b done=%b pp=%h want 0 0 0000",
                     busy8, done8, pp8);
        end
        tick();
        #2 rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done8 || busy8) cnt++;
        end
        n_checks++;
        if (cnt !== 0) begin
            n_fail++;
            $display("FAIL abort_no_done: active cycles=%0d want 0", cnt);
        end
        start8(8'd7, 8'd9);
        wait_done8(n);
        n_checks++;
        if (n !== 11 || pp8 !== 16'd63) begin
            n_fail++;
            $display("FAIL abort_rerun: edges=%0d pp=%0d want 11 63", n, pp8);
        end
        hold8(h);
    endtask

`ifdef MULT_SIGNED_EN
    task automatic test_signed();
        int n, h;
        start8(8'hFD, 8'd5);
        wait_done8(n);
        n_checks++;
        if (n !== 9 || pp8 !== 16'hFFF1) begin
            n_fail++;
            $display("FAIL signed_neg3x5: edges=%0d pp=%h want 9 fff1", n, pp8);
        end
        hold8(h);
        start8(8'h80, 8'h80);
        wait_done8(n);
        n_checks++;
        if (n !== 18 || pp8 !== 16'h4000) begin
            n_fail++;
            $display("FAIL signed_min_sq: edges=%0d pp=%h want 18 4000", n, pp8);
        end
        hold8(h);
        start8(8'h80, 8'd1);
        wait_done8(n);
        n_checks++;
        if (n !== 4 || pp8 !== 16'hFF80) begin
            n_fail++;
            $display("FAIL signed_min_x1: edges=%0d pp=%h want 4 ff80", n, pp8);
        end
        hold8(h);
    endtask
`endif

    task automatic test_wide();
        int n, h;
        tick();
        init16 = 1'b1;
        a16 = 16'hFFFF;
        b16 = 16'hFFFF;
        tick();
        init16 = 1'b0;
        n = 0;
        while (!done16 && n < 400) begin
            tick();
            n++;
        end
        n_checks++;
        if (n !== N_W) begin
            n_fail++;
            $display("FAIL wide_latency: got %0d edges want %0d", n, N_W);
        end
        n_checks++;
        if (pp16 !== EXP_W) begin
            n_fail++;
            $display("FAIL wide_pp: got %h want %h", pp16, EXP_W);
        end
        h = 0;
        while (done16 && h < 300) begin
            tick();
            h++;
        end
        n_checks++;
        if (h !== 1 || busy16 !== 1'b0) begin
            n_fail++;
            $display("FAIL wide_hold: cycles=%0d busy=%b want 1 0", h, busy16);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_back_to_back();
        test_reset_abort();
`ifdef MULT_SIGNED_EN
        test_signed();
`endif
        test_wide();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
